// File: rtl/slow_clock_pkg.sv
// slow_clock_pkg: shared mode and state encodings for the slow clock generator
package slow_clock_pkg;
    typedef enum logic [1:0] {MODE_RUN = 2'd0, MODE_STEP = 2'd1, MODE_HOLD = 2'd2} mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} state_t;
endpackage

// File: rtl/slow_clock_gen_edge_sync.sv
// edge_sync: two-flop synchroniser with a one-cycle rising-edge pulse
module edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic pulse_o
);
    logic [2:0] sync_q;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[1:0], d_i};
    assign pulse_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/slow_clock_gen.sv
// slow_clock_gen: 50%-duty divided clock with RUN/STEP/HOLD modes and
// registered RISE/FALL strobes; the divisor only changes between periods.
module slow_clock_gen
    import slow_clock_pkg::*;
#(
    parameter int CLOCK_HZ  = 100_000_000,
    parameter int SEL_WIDTH = 4,
    parameter int CNT_WIDTH = $clog2(CLOCK_HZ)
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [SEL_WIDTH-1:0] SELECT,
    input  logic [1:0]           MODE,
    input  logic                 STEP,
    output logic                 SLOW_CLOCK,
    output logic                 RISE,
    output logic                 FALL,
    output logic [CNT_WIDTH-1:0] COUNT,
    output logic                 BUSY
);
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, half_raw, half;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic                   slow_q, slow_d, rise_q, rise_d, fall_q, fall_d;
    logic                   step_edge, last;
    mode_t                  mode;

    edge_sync u_step (.clk_i(CLOCK), .rst_i(RESET), .d_i(STEP), .pulse_o(step_edge));

    assign mode     = mode_t'(MODE);
    // Large exponents shift everything out; clamp so the fastest rate is CLOCK/2.
    assign half_raw = CNT_WIDTH'(CLOCK_HZ >> (32'(sel_q) + 32'd1));
    assign half     = (half_raw == '0) ? CNT_WIDTH'(1) : half_raw;
    assign last     = cnt_q == half - CNT_WIDTH'(1);

    always_ff @(posedge CLOCK or posedge RESET)
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            slow_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            slow_q  <= slow_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = (mode == MODE_RUN) ? ST_LOW :
                               (mode == MODE_STEP && step_edge) ? ST_HIGH : ST_IDLE;
            ST_LOW:  state_d = last ? ST_HIGH : ST_LOW;
            ST_HIGH: state_d = !last ? ST_HIGH : (mode == MODE_RUN) ? ST_LOW : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        slow_d = slow_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                slow_d = state_d == ST_HIGH;
                rise_d = state_d == ST_HIGH;
                sel_d  = (state_d != ST_IDLE) ? SELECT : sel_q;
            end
            ST_LOW: begin
                cnt_d  = last ? '0 : cnt_q + CNT_WIDTH'(1);
                slow_d = last;
                rise_d = last;
            end
            ST_HIGH: begin
                cnt_d  = last ? '0 : cnt_q + CNT_WIDTH'(1);
                slow_d = !last;
                fall_d = last;
                sel_d  = last ? SELECT : sel_q;
            end
            default: cnt_d = '0;
        endcase
    end

    assign SLOW_CLOCK = slow_q;
    assign RISE       = rise_q;
    assign FALL       = fall_q;
    assign COUNT      = cnt_q;
    assign BUSY       = state_q != ST_IDLE;
endmodule

// File: tb/tb_slow_clock_gen.sv
// tb_slow_clock_gen: directed checks of slow_clock_gen at CLOCK_HZ=16
module tb_slow_clock_gen;
    logic       clk = 1'b0, rst = 1'b1, step = 1'b0;
    logic [3:0] sel = 4'd0;
    logic [1:0] mode = 2'd0;
    logic       slow, rise, fall, busy;
    logic [3:0] count;
    int         checks = 0, errors = 0;

    slow_clock_gen #(.CLOCK_HZ(16), .SEL_WIDTH(4)) dut (
        .CLOCK(clk), .RESET(rst), .SELECT(sel), .MODE(mode), .STEP(step),
        .SLOW_CLOCK(slow), .RISE(rise), .FALL(fall), .COUNT(count), .BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] obs();
        return {24'd0, slow, rise, fall, busy, count};
    endfunction

    // lvl phase of len cycles, count starting at start; strobe on its first cycle if asked
    task automatic phase(input string tag, input logic lvl, input int len,
                         input logic strobe, input int start);
        for (int i = 0; i < len; i++) begin
            logic s;
            tick();
            s = strobe && i == 0;
            chk(tag, obs(), {24'd0, lvl, s && lvl, s && !lvl, 1'b1, 4'(start + i)});
        end
    endtask

    task automatic idle(input string tag, input int len, input logic fall_first);
        for (int i = 0; i < len; i++) begin
            tick();
            chk(tag, obs(), {24'd0, 1'b0, 1'b0, fall_first && i == 0, 1'b0, 4'd0});
        end
    endtask

    task automatic restart(input logic [3:0] s, input logic [1:0] m);
        rst = 1'b1;
        sel = s;
        mode = m;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        chk("reset", obs(), 32'd0);
        // plain RUN at SELECT=0: 8 low, 8 high, repeating
        restart(4'd0, 2'd0);
        phase("run_lo0", 1'b0, 8, 1'b0, 0);
        phase("run_hi0", 1'b1, 8, 1'b1, 0);
        phase("run_lo1", 1'b0, 8, 1'b1, 0);
        phase("run_hi1", 1'b1, 8, 1'b1, 0);
        // SELECT=3 and SELECT=9 both give half=1
        restart(4'd3, 2'd0);
        phase("s3_lo0", 1'b0, 1, 1'b0, 0);
        for (int r = 0; r < 4; r++) begin
            phase("s3_hi", 1'b1, 1, 1'b1, 0);
            phase("s3_lo", 1'b0, 1, 1'b1, 0);
        end
        restart(4'd9, 2'd0);
        phase("s9_lo0", 1'b0, 1, 1'b0, 0);
        for (int r = 0; r < 4; r++) begin
            phase("s9_hi", 1'b1, 1, 1'b1, 0);
            phase("s9_lo", 1'b0, 1, 1'b1, 0);
        end
        // SELECT change mid-HIGH applies from the next period
        restart(4'd0, 2'd0);
        phase("sel_lo0", 1'b0, 8, 1'b0, 0);
        phase("sel_hi_a", 1'b1, 4, 1'b1, 0);
        sel = 4'd1;
        phase("sel_hi_b", 1'b1, 4, 1'b0, 4);
        phase("sel_lo", 1'b0, 4, 1'b1, 0);
        phase("sel_hi", 1'b1, 4, 1'b1, 0);
        phase("sel_lo2", 1'b0, 4, 1'b1, 0);
        // STEP held 20 cycles: one period only
        restart(4'd0, 2'd1);
        idle("step_idle", 3, 1'b0);
        step = 1'b1;
        idle("step_sync", 2, 1'b0);
        phase("step_hi", 1'b1, 8, 1'b1, 0);
        idle("step_done", 10, 1'b1);
        step = 1'b0;
        idle("step_rel", 4, 1'b0);
        // second press during HIGH is discarded
        step = 1'b1;
        idle("step2_sync", 2, 1'b0);
        phase("step2_hi_a", 1'b1, 2, 1'b1, 0);
        step = 1'b0;
        phase("step2_hi_b", 1'b1, 2, 1'b0, 2);
        step = 1'b1;
        phase("step2_hi_c", 1'b1, 4, 1'b0, 4);
        idle("step2_done", 6, 1'b1);
        // RUN->HOLD during LOW completes the period
        restart(4'd0, 2'd0);
        phase("hold_lo_a", 1'b0, 3, 1'b0, 0);
        mode = 2'd2;
        phase("hold_lo_b", 1'b0, 5, 1'b0, 3);
        phase("hold_hi", 1'b1, 8, 1'b1, 0);
        idle("hold_idle", 5, 1'b1);
        // async reset mid-HIGH
        restart(4'd0, 2'd0);
        phase("ar_lo", 1'b0, 8, 1'b0, 0);
        phase("ar_hi", 1'b1, 3, 1'b1, 0);
        #2 rst = 1'b1;
        #1 chk("async_rst", obs(), 32'd0);
        tick();
        chk("rst_hold", obs(), 32'd0);
        rst = 1'b0;
        phase("ar_lo2", 1'b0, 8, 1'b0, 0);
        phase("ar_hi2", 1'b1, 8, 1'b1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/slow_clock_gen.md
Name: slow_clock_gen

Overview:
- Parametrised successor to the fixed slow-clock divider. Generates a 50%-duty SLOW_CLOCK from the board clock at CLOCK_HZ / 2^(SELECT+1) per half-period.
- Adds glitch-free divisor changes, RUN/STEP/HOLD modes with single-step on a button, and registered one-cycle RISE/FALL strobes for the UART sender and LED logic.
- Sits between the board clock and the CPU/LED/UART blocks in top.

Parameters:
- CLOCK_HZ, 100_000_000, board clock frequency; the full divisor at SELECT=0.
- SEL_WIDTH, 4, width of SELECT.
- CNT_WIDTH, $clog2(CLOCK_HZ), width of the internal phase counter and the COUNT port.

Ports:
- CLOCK  input  1  board clock; all flops on posedge.
- RESET  input  1  asynchronous, active-high reset.
- SELECT  input  SEL_WIDTH  divide exponent, sampled only at period boundaries.
- MODE  input  2  0=RUN, 1=STEP, 2=HOLD, 3=HOLD (reserved).
- STEP  input  1  asynchronous button; each rising edge gives one slow period in STEP mode.
- SLOW_CLOCK  output  1  divided clock, registered.
- RISE  output  1  high for exactly one CLOCK cycle: the first cycle SLOW_CLOCK reads 1.
- FALL  output  1  high for exactly one CLOCK cycle: the first cycle SLOW_CLOCK reads 0 after a high phase.
- COUNT  output  CNT_WIDTH  current phase counter, for the LED dimmer.
- BUSY  output  1  high while in LOW or HIGH state.

Behaviour:
- Reset (async, any time, including mid-period):
  - state=IDLE; SLOW_CLOCK=0, RISE=0, FALL=0, COUNT=0, BUSY=0.
  - sel_q=0; STEP synchroniser flops cleared.
- half = CLOCK_HZ >> (sel_q+1), computed in CNT_WIDTH bits.
  - If the result is 0, half=1 (SLOW_CLOCK = CLOCK/2).
  - Covers SELECT values at or above CNT_WIDTH.
- sel_q loads from SELECT only in these two cases, so a period never mixes divisors:
  - on an IDLE->LOW or IDLE->HIGH transition;
  - on a HIGH-phase end.
- STEP path:
  - 2-flop synchroniser plus edge register; step_edge = s2 & ~s3.
  - If STEP is first sampled high at edge k, SLOW_CLOCK=1 and RISE=1 after edge k+2.
- States:
  - IDLE: SLOW_CLOCK=0, COUNT=0.
    - MODE=RUN -> LOW, latch sel_q.
    - MODE=STEP and step_edge -> HIGH, SLOW_CLOCK<=1, RISE<=1, latch sel_q.
    - Otherwise stay in IDLE.
  - LOW:
    - COUNT==half-1 -> HIGH, COUNT<=0, SLOW_CLOCK<=1, RISE<=1.
    - Otherwise COUNT++.
  - HIGH:
    - COUNT==half-1 -> SLOW_CLOCK<=0, FALL<=1, COUNT<=0, latch sel_q; next state is LOW if MODE==RUN, else IDLE.
    - Otherwise COUNT++.
- Each phase lasts exactly `half` CLOCK cycles, so the RUN period is 2*half cycles.
- MODE changes take effect only in IDLE or at a HIGH-phase end. A period already started always completes in full, so a RUN->HOLD switch never truncates a pulse.
- step_edge outside IDLE-with-MODE=STEP is discarded; it is not queued.
- RISE and FALL are never high in the same cycle. Each is held high for exactly one cycle, even when half=1.

Decomposition:
- Package slow_clock_pkg:
  - enum mode_t {MODE_RUN=2'd0, MODE_STEP=2'd1, MODE_HOLD=2'd2};
  - enum state_t {ST_IDLE, ST_LOW, ST_HIGH}.
- One sub-module, edge_sync: 2-flop synchroniser with rising-edge pulse output, async active-high reset. It is reusable for the other PHYSICAL_BUTTON inputs.

Test Plan:
- CLOCK_HZ=16, SELECT=0, MODE=RUN, release RESET -> after IDLE->LOW, SLOW_CLOCK is low for 8 cycles then high for 8, repeating. RISE and FALL are each one-cycle pulses every 16 cycles.
- CLOCK_HZ=16, SELECT=3 (half=1), then SELECT=9 (half clamps to 1) -> SLOW_CLOCK toggles every cycle. RISE and FALL alternate and are never coincident.
- RUN, SELECT=0; change SELECT to 1 mid-HIGH -> current high phase stays 8 cycles; the next phases are 4 cycles each.
- MODE=STEP; assert STEP at edge k, hold it for 20 cycles -> SLOW_CLOCK is high after edge k+2 for 8 cycles then returns to IDLE. Exactly one RISE and one FALL; a second press during HIGH produces nothing.
- RUN; switch MODE to HOLD during LOW -> the period completes (remaining low cycles, then 8 high), FALL fires, then IDLE with SLOW_CLOCK=0 and BUSY=0.
- Assert RESET asynchronously mid-HIGH, between clock edges -> SLOW_CLOCK, RISE, FALL and COUNT go to 0 immediately. RUN resumes with a full low phase after release.
